// File: rtl/ds_pkg.sv
// DS18B20 measurement sequencer: shared command bytes, FSM states
// and the op-state successor function.
package ds_pkg;

  localparam logic [7:0] DS_CMD_SKIP_ROM = 8'hCC;
  localparam logic [7:0] DS_CMD_CONVERT  = 8'h44;
  localparam logic [7:0] DS_CMD_READ_SP  = 8'hBE;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RST1,
    S_SKIP1,
    S_CONV,
    S_WCONV,
    S_RST2,
    S_SKIP2,
    S_RDCMD,
    S_RDL,
    S_RDH,
    S_DONE
  } state_e;

  typedef enum logic {
    PH_ISSUE,
    PH_WAIT
  } phase_e;

  function automatic state_e ds_next(state_e s);
    state_e n;
    unique case (s)
      S_RST1:  n = S_SKIP1;
      S_SKIP1: n = S_CONV;
      S_CONV:  n = S_WCONV;
      S_WCONV: n = S_RST2;
      S_RST2:  n = S_SKIP2;
      S_SKIP2: n = S_RDCMD;
      S_RDCMD: n = S_RDL;
      S_RDL:   n = S_RDH;
      S_RDH:   n = S_DONE;
      default: n = S_IDLE;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/ds_wait_timer.sv
// Shared conversion-wait / watchdog counter.
// clr,en in; cnt out; hit_conv/hit_tmo flag CONV_CYC-1 / TMO_CYC-1.
module ds_wait_timer #(
  parameter int CONV_CYC = 37_500_000,
  parameter int TMO_CYC  = 5_000_000,
  parameter int CNT_W    = 26
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             hit_conv,
  output logic             hit_tmo
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt      = cnt_q;
  assign hit_conv = (cnt_q == CNT_W'(CONV_CYC - 1));
  assign hit_tmo  = (cnt_q == CNT_W'(TMO_CYC - 1));

endmodule

// File: rtl/ds_temp_ctrl.sv
// DS18B20 sequencer: one measurement per start, drives the byte layer
// (rst_en/wr_en/rd_en/wdata; rdy/rdata/rdata_vld) and returns temp/err.
module ds_temp_ctrl #(
  parameter int CONV_CYC = 37_500_000,
  parameter int TMO_CYC  = 5_000_000,
  parameter int CNT_W    = 26
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic [15:0] temp,
  output logic        temp_vld,
  output logic        err,
  output logic        rst_en,
  output logic        wr_en,
  output logic [7:0]  wdata,
  output logic        rd_en,
  input  logic [7:0]  rdata,
  input  logic        rdata_vld,
  input  logic        rdy
);

  import ds_pkg::*;

  state_e      state_q, state_d;
  phase_e      phase_q, phase_d;
  logic        rst_en_q, rst_en_d;
  logic        wr_en_q, wr_en_d;
  logic        rd_en_q, rd_en_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        err_q, err_d;
  logic [7:0]  lsb_q, lsb_d;
  logic [15:0] temp_q, temp_d;

  logic [CNT_W-1:0] cnt;
  logic hit_conv;
  logic hit_tmo;
  logic tmr_clr;
  logic is_rst;
  logic is_rd;
  logic op_end;
  logic [7:0] cmd;

  ds_wait_timer #(
    .CONV_CYC (CONV_CYC),
    .TMO_CYC  (TMO_CYC),
    .CNT_W    (CNT_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (tmr_clr),
    .en       (busy),
    .cnt      (cnt),
    .hit_conv (hit_conv),
    .hit_tmo  (hit_tmo)
  );

  assign busy     = (state_q != S_IDLE) && (state_q != S_DONE);
  assign temp_vld = (state_q == S_DONE);
  assign is_rst   = (state_q == S_RST1) || (state_q == S_RST2);
  assign is_rd    = (state_q == S_RDL) || (state_q == S_RDH);

  always_comb begin
    cmd = DS_CMD_SKIP_ROM;
    unique case (1'b1)
      (state_q == S_CONV):  cmd = DS_CMD_CONVERT;
      (state_q == S_RDCMD): cmd = DS_CMD_READ_SP;
      default:              cmd = DS_CMD_SKIP_ROM;
    endcase
  end

  // First WAIT cycle has cnt==0; rdy there still reflects the old op.
  assign op_end = is_rd ? rdata_vld : (rdy && (cnt != '0));

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    rst_en_d = 1'b0;
    wr_en_d  = 1'b0;
    rd_en_d  = 1'b0;
    wdata_d  = wdata_q;
    err_d    = 1'b0;
    lsb_d    = lsb_q;
    temp_d   = temp_q;
    unique case (state_q)
      S_IDLE: begin
        // err_q marks the abort cycle, where start is not accepted.
        if (start && !err_q) begin
          state_d = S_RST1;
          phase_d = PH_ISSUE;
        end
      end
      S_WCONV: begin
        if (hit_conv) begin
          state_d = S_RST2;
          phase_d = PH_ISSUE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        phase_d = PH_ISSUE;
      end
      default: begin
        if (hit_tmo) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
          phase_d = PH_ISSUE;
        end else if (phase_q == PH_ISSUE) begin
          if (rdy) begin
            phase_d = PH_WAIT;
            if (is_rst) begin
              rst_en_d = 1'b1;
            end else if (is_rd) begin
              rd_en_d = 1'b1;
            end else begin
              wr_en_d = 1'b1;
              wdata_d = cmd;
            end
          end
        end else if (op_end) begin
          if (state_q == S_RDL) begin
            lsb_d = rdata;
          end
          if (state_q == S_RDH) begin
            temp_d = {rdata, lsb_q};
          end
          state_d = ds_next(state_q);
          phase_d = PH_ISSUE;
        end
      end
    endcase
  end

  assign tmr_clr = (state_d != state_q) || (phase_d != phase_q) || !busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      phase_q  <= PH_ISSUE;
      rst_en_q <= 1'b0;
      wr_en_q  <= 1'b0;
      rd_en_q  <= 1'b0;
      wdata_q  <= 8'h00;
      err_q    <= 1'b0;
      lsb_q    <= 8'h00;
      temp_q   <= 16'h0000;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      rst_en_q <= rst_en_d;
      wr_en_q  <= wr_en_d;
      rd_en_q  <= rd_en_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
      lsb_q    <= lsb_d;
      temp_q   <= temp_d;
    end
  end

  assign rst_en = rst_en_q;
  assign wr_en  = wr_en_q;
  assign rd_en  = rd_en_q;
  assign wdata  = wdata_q;
  assign err    = err_q;
  assign temp   = temp_q;

endmodule
